// File: rtl/arbitro_rr_param.sv
// Arbiter between the input and output FIFO banks: pops one input FIFO per cycle
// (fixed priority or round robin) and pushes the popped word to its dest output FIFO one cycle later.
module arbitro_rr_param #(
   parameter int N_IN       = 4,
   parameter int SEL_W      = 2,
   parameter int DEST_W     = 2,
   parameter int MODE       = 1,
   parameter int RESUME_DLY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_IN-1:0]        empty,
   input  logic [(2**DEST_W)-1:0] afull,
   input  logic [DEST_W-1:0]      dest,
   output logic [N_IN-1:0]        pop,
   output logic [(2**DEST_W)-1:0] push,
   output logic [SEL_W-1:0]       sel,
   output logic [1:0]             state,
   output logic                   busy
);
   localparam int N_OUT = 2**DEST_W;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      STALL = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q;
   logic             pending_q;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_found;
   logic             any_afull, all_empty, pop_ok;

   assign any_afull = |afull;
   assign all_empty = &empty;

   // Handshake: pop[i] in cycle t consumes FIFO i's word at edge t; that word's dest is valid
   // in t+1, where push[dest] and sel carry it. The push is never held back: the output FIFO
   // almost-full margin absorbs the single in-flight word.
   always_comb begin
      int j;
      j           = 0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         j = (MODE == 0) ? k : int'(ptr_q) + k;
         if (j >= N_IN) j = j - N_IN;
         if (!grant_found && !empty[SEL_W'(j)]) begin
            grant_found = 1'b1;
            grant_idx   = SEL_W'(j);
         end
      end
   end

   assign pop_ok = reset && (state_q != STALL) && !any_afull && grant_found;
   assign pop    = pop_ok ? (N_IN'(1) << grant_idx) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (MODE != 0 && pop_ok)
         ptr_d = (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Stall exit waits RESUME_DLY quiet edges after the almost-full flags drop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (any_afull) begin
         state_d = STALL;
         cnt_d   = 4'(RESUME_DLY);
      end else if (state_q == STALL && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         state_d = all_empty ? IDLE : RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= '0;
         sel_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         pending_q <= pop_ok;
         if (pop_ok) sel_q <= grant_idx;
      end
   end

   assign push  = pending_q ? (N_OUT'(1) << dest) : '0;
   assign sel   = sel_q;
   assign state = state_q;
   assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Bench for arbitro_rr_param: round-robin, fixed-priority and 8-input instances driven
// from one clock, with a cycle model of the round-robin instance.
module tb_arbitro_rr_param;
   localparam int RD = 2;

   typedef struct {
      logic [3:0] empty;
      logic [3:0] afull;
      logic [3:0] exp_pop;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] empty, afull;
   logic [1:0] dest;
   logic [3:0] pop, push, fp_pop, fp_push;
   logic [1:0] sel, state, fp_sel, fp_state;
   logic       busy, fp_busy;
   logic [7:0] empty8, afull8, pop8, push8;
   logic [2:0] dest8, sel8;
   logic [1:0] state8;
   logic       busy8;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_q[$];
   int         m_state, m_quiet, m_ptr;
   logic [1:0] m_last_sel;

   logic [3:0] o_pop, o_push, o_fp_pop, o_fp_push;
   logic [1:0] o_sel, o_state, o_fp_sel, o_fp_state;
   logic       o_fp_busy, o_busy8;
   logic [7:0] o_pop8, o_push8;
   logic [2:0] o_sel8;
   logic [1:0] o_state8;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   arbitro_rr_param #(.N_IN(4), .SEL_W(2), .DEST_W(2), .MODE(1), .RESUME_DLY(RD)) dut_rr (
      .clk(clk), .reset(reset), .empty(empty), .afull(afull), .dest(dest),
      .pop(pop), .push(push), .sel(sel), .state(state), .busy(busy)
   );

   arbitro_rr_param #(.N_IN(4), .SEL_W(2), .DEST_W(2), .MODE(0), .RESUME_DLY(RD)) dut_fp (
      .clk(clk), .reset(reset), .empty(empty), .afull(afull), .dest(dest),
      .pop(fp_pop), .push(fp_push), .sel(fp_sel), .state(fp_state), .busy(fp_busy)
   );

   arbitro_rr_param #(.N_IN(8), .SEL_W(3), .DEST_W(3), .MODE(1), .RESUME_DLY(RD)) dut8 (
      .clk(clk), .reset(reset), .empty(empty8), .afull(afull8), .dest(dest8),
      .pop(pop8), .push(push8), .sel(sel8), .state(state8), .busy(busy8)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state    = 0;
      m_quiet    = 0;
      m_ptr      = 0;
      m_last_sel = 2'd0;
      exp_q.delete();
   endtask

   // driver: inputs are set at the falling edge, outputs sampled 1 time unit later,
   // model advanced at the rising edge, returns at the next falling edge
   task automatic step();
      bit         g_valid;
      int         g_idx;
      logic [3:0] e_pop, e_push;
      logic [1:0] e_sel;
      #1;
      if (!reset) model_reset();
      g_valid = 1'b0;
      g_idx   = 0;
      if (reset && m_state != 2 && afull == 4'b0000)
         for (int k = 0; k < 4; k++)
            if (!g_valid && empty[2'((m_ptr + k) % 4)] == 1'b0) begin
               g_valid = 1'b1;
               g_idx   = (m_ptr + k) % 4;
            end
      e_pop  = g_valid ? (4'b0001 << g_idx) : 4'b0000;
      e_push = (exp_q.size() != 0) ? (4'b0001 << dest) : 4'b0000;
      e_sel  = (exp_q.size() != 0) ? exp_q[0] : m_last_sel;

      o_pop = pop;  o_push = push;  o_sel = sel;  o_state = state;
      o_fp_pop = fp_pop;  o_fp_push = fp_push;  o_fp_sel = fp_sel;
      o_fp_state = fp_state;  o_fp_busy = fp_busy;
      o_pop8 = pop8;  o_push8 = push8;  o_sel8 = sel8;  o_state8 = state8;  o_busy8 = busy8;

      check("rr_pop", 16'(pop), 16'(e_pop));
      check("rr_push", 16'(push), 16'(e_push));
      check("rr_sel", 16'(sel), 16'(e_sel));
      check("rr_state", 16'(state), 16'(m_state));
      check("rr_busy", 16'(busy), 16'(m_state == 1));

      @(posedge clk);
      if (reset) begin
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (g_valid) begin
            exp_q.push_back(2'(g_idx));
            m_last_sel = 2'(g_idx);
            m_ptr      = (g_idx + 1) % 4;
         end
         if (afull != 4'b0000) begin
            m_state = 2;
            m_quiet = 0;
         end else if (m_state == 2 && m_quiet < RD) begin
            m_quiet++;
         end else begin
            m_state = (empty == 4'b1111) ? 0 : 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      vec_t tbl[10];
      tbl[0] = '{4'b1111, 4'b0000, 4'b0000};
      tbl[1] = '{4'b0000, 4'b0000, 4'b0001};
      tbl[2] = '{4'b0001, 4'b0000, 4'b0010};
      tbl[3] = '{4'b0011, 4'b0000, 4'b0100};
      tbl[4] = '{4'b0111, 4'b0000, 4'b1000};
      tbl[5] = '{4'b1010, 4'b0000, 4'b0001};
      tbl[6] = '{4'b1100, 4'b0000, 4'b0001};
      tbl[7] = '{4'b1011, 4'b0000, 4'b0100};
      tbl[8] = '{4'b1110, 4'b0000, 4'b0001};
      tbl[9] = '{4'b0000, 4'b0001, 4'b0000};

      reset = 1'b0;  empty = 4'b0000;  afull = 4'b0000;  dest = 2'd0;
      empty8 = 8'hff;  afull8 = 8'h00;  dest8 = 3'd0;
      model_reset();
      @(negedge clk);

      // reset state, then same-cycle pop on release
      step();
      check("rst_pop", 16'(o_pop), 16'h0);
      check("rst_push", 16'(o_push), 16'h0);
      check("rst_state", 16'(o_state), 16'h0);
      reset = 1'b1;
      dest  = 2'd2;
      step();
      check("rel_pop", 16'(o_pop), 16'h1);
      step();
      check("rel_push", 16'(o_push), 16'h4);
      check("rel_sel", 16'(o_sel), 16'h0);

      // all FIFOs non-empty: rotation vs. fixed priority
      do_reset();
      empty = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         dest = 2'(3 - (k % 4));
         step();
         check("rr_seq_pop", 16'(o_pop), 16'(4'b0001 << (k % 4)));
         check("fp_seq_pop", 16'(o_fp_pop), 16'h1);
         if (k > 0) begin
            check("rr_seq_sel", 16'(o_sel), 16'((k - 1) % 4));
            check("rr_seq_push", 16'(o_push), 16'(4'b0001 << dest));
            check("fp_seq_sel", 16'(o_fp_sel), 16'h0);
            check("fp_seq_push", 16'(o_fp_push), 16'(4'b0001 << dest));
            check("fp_seq_busy", 16'(o_fp_busy), 16'h1);
         end
      end
      empty = 4'b0001;
      step();
      check("fp_skip0_pop", 16'(o_fp_pop), 16'h2);

      // fixed-priority vector table
      do_reset();
      for (int i = 0; i < 10; i++) begin
         empty = tbl[i].empty;
         afull = tbl[i].afull;
         dest  = 2'($urandom_range(0, 3));
         step();
         check("fp_tbl_pop", 16'(o_fp_pop), 16'(tbl[i].exp_pop));
      end
      afull = 4'b0000;

      // stall and resume hysteresis
      do_reset();
      empty = 4'b0000;
      dest  = 2'd3;
      for (int c = 1; c <= 14; c++) begin
         afull = (c >= 5 && c <= 9) ? 4'b0100 : 4'b0000;
         step();
         if (c == 5) begin
            check("stall_c5_pop", 16'(o_pop), 16'h0);
            check("stall_c5_fp_pop", 16'(o_fp_pop), 16'h0);
            check("stall_c5_push", 16'(o_push), 16'h8);
            check("stall_c5_sel", 16'(o_sel), 16'h3);
            check("stall_c5_state", 16'(o_state), 16'h1);
         end
         if (c >= 6 && c <= 12) begin
            check("stall_state", 16'(o_state), 16'h2);
            check("stall_pop", 16'(o_pop), 16'h0);
         end
         if (c == 6) check("stall_fp_state", 16'(o_fp_state), 16'h2);
         if (c == 13) begin
            check("resume_pop", 16'(o_pop), 16'h1);
            check("resume_state", 16'(o_state), 16'h1);
         end
         if (c == 14) begin
            check("resume_push", 16'(o_push), 16'h8);
            check("resume_sel", 16'(o_sel), 16'h0);
         end
      end
      afull = 4'b0000;

      // reset right after a pop drops the pending push
      do_reset();
      empty = 4'b0000;
      step();
      step();
      reset = 1'b0;
      step();
      check("midrst_push", 16'(o_push), 16'h0);
      check("midrst_pop", 16'(o_pop), 16'h0);
      check("midrst_sel", 16'(o_sel), 16'h0);
      check("midrst_state", 16'(o_state), 16'h0);
      reset = 1'b1;
      step();
      check("postrst_state", 16'(o_state), 16'h0);
      check("postrst_pop", 16'(o_pop), 16'h1);

      // 8-input wrap: pointer reaches 7, then grants 1, 6, 1
      empty = 4'b1111;
      do_reset();
      empty8 = 8'b1011_1111;
      step();
      check("w8_pop_first", 16'(o_pop8), 16'h40);
      check("w8_state_idle", 16'(o_state8), 16'h0);
      empty8 = 8'b1011_1101;
      dest8  = 3'b101;
      step();
      check("w8_pop_wrap", 16'(o_pop8), 16'h02);
      check("w8_push", 16'(o_push8), 16'h20);
      check("w8_sel6", 16'(o_sel8), 16'h6);
      check("w8_busy", 16'(o_busy8), 16'h1);
      step();
      check("w8_pop_6", 16'(o_pop8), 16'h40);
      check("w8_sel1", 16'(o_sel8), 16'h1);
      step();
      check("w8_pop_1", 16'(o_pop8), 16'h02);
      check("w8_sel6b", 16'(o_sel8), 16'h6);
      empty8 = 8'hff;
      step();
      check("w8_pop_none", 16'(o_pop8), 16'h00);
      check("w8_push_last", 16'(o_push8), 16'h20);
      check("w8_sel_last", 16'(o_sel8), 16'h1);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 59) != 0);
         empty = 4'($urandom_range(0, 15));
         afull = ($urandom_range(0, 7) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
         dest  = 2'($urandom_range(0, 3));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
